flash_spi_responder: RTL and testbench

FLASH_SPI_RESPONDER -- requirements
Module: flash_spi_responder

---
 rtl/flash_spi_pkg.sv | 41 ++++
 rtl/spi_edge_sync.sv | 40 ++++
 rtl/flash_spi_responder.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_flash_spi_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_spi_pkg.sv
// Shared definitions for the SPI flash responder.
// Holds the opcode values, the protocol FSM states and the status-register bit layout.
package flash_spi_pkg;

    // Opcodes understood by the responder
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_RDID  = 8'h90;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_SE    = 8'h20;

    // Status register bit positions
    localparam int STAT_WIP_BIT = 0;
    localparam int STAT_WEL_BIT = 1;

    // Protocol FSM states
    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD_DATA,
        WR_DATA,
        STATUS,
        ID_OUT,
        IGNORE
    } spi_state_e;

    // Builds the status byte {6'b0, WEL, WIP}
    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_WEL_BIT] = wel;
        s[STAT_WIP_BIT] = wip;
        return s;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the system clock domain.
// Each pin passes through two flops; SCK and CS_n get a third flop so their
// rising and falling edges can be reported as single-cycle strobes.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck_i};
            cs_q   <= {cs_q[1:0], cs_n_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/flash_spi_responder.sv
// Behavioural SPI NOR flash responder (mode 0) with an internal 2^AW byte array.
// Supports WREN/WRDI, RDSR, READ, RDID, page program and sector erase, with a
// WIP busy timer after program/erase. Optional fast read (0x0B with eight dummy
// clocks) is compiled in when FLASH_SPI_RESP_FAST_READ_EN is defined.
// AW is expected to be between 8 and 24.
module flash_spi_responder
    import flash_spi_pkg::*;
#(
    parameter int         AW           = 10,
    parameter logic [7:0] MFR_ID       = 8'hEF,
    parameter logic [7:0] DEV_ID       = 8'h16,
    parameter int         PROG_CYCLES  = 64,
    parameter int         ERASE_CYCLES = 1024
) (
    input  logic       clock25M,
    input  logic       flash_rstn,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       busy,
    output logic       wel,
    output logic       cmd_strobe,
    output logic [7:0] cmd_code
);

    localparam int DEPTH     = 1 << AW;
    localparam int SB        = (AW > 12) ? 12 : AW;
    localparam int SECT_SIZE = 1 << SB;
    localparam int FW        = AW + 1;
    localparam int BUSY_MAX  = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int CW        = $clog2(BUSY_MAX + 1);
    localparam logic [AW-1:0] LOW_MASK  = AW'(SECT_SIZE - 1);
    localparam logic [AW-1:0] PAGE_MASK = AW'(8'hFF);

    logic        sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

    spi_edge_sync u_sync (
        .clk      (clock25M),
        .rst_n    (flash_rstn),
        .sck_i    (spi_sck),
        .cs_n_i   (spi_cs_n),
        .mosi_i   (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_s   (mosi_s)
    );

    spi_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        wip_q, wip_d;
    logic        wel_q, wel_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  code_q, code_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] addr_acc_q, addr_acc_d;
    logic [1:0]  addr_cnt_q, addr_cnt_d;
    logic        id_sel_q, id_sel_d;
    logic        wr_any_q, wr_any_d;
    logic        erase_arm_q, erase_arm_d;
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic [AW-1:0] fill_addr_q, fill_addr_d;
    logic [FW-1:0] fill_left_q, fill_left_d;

    logic [7:0]  mem [0:DEPTH-1];
    logic        mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [AW-1:0] rd_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  rx_byte;
    logic [AW-1:0] new_addr;

    assign rx_byte   = {rx_sr_q, mosi_s};
    assign new_addr  = (addr_acc_q << 8) | AW'(rx_byte);
    assign mem_rdata = mem[rd_addr];

    // The first data byte of a read must come from the address still being assembled
    always_comb begin
        rd_addr = addr_q;
        if (state_q == ADDR && addr_cnt_q == 2'd2) begin
            rd_addr = new_addr;
        end
    end

    // Next-state logic: busy timer / erase fill engine, then the SPI protocol
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        wip_d       = wip_q;
        wel_d       = wel_q;
        strobe_d    = 1'b0;
        code_d      = code_q;
        addr_d      = addr_q;
        addr_acc_d  = addr_acc_q;
        addr_cnt_d  = addr_cnt_q;
        id_sel_d    = id_sel_q;
        wr_any_d    = wr_any_q;
        erase_arm_d = erase_arm_q;
        busy_cnt_d  = busy_cnt_q;
        fill_addr_d = fill_addr_q;
        fill_left_d = fill_left_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = 8'hFF;

        // WIP stays up until both the timer and the erase fill have finished
        if (wip_q) begin
            if (fill_left_q != '0) begin
                mem_we      = 1'b1;
                mem_waddr   = fill_addr_q;
                mem_wdata   = 8'hFF;
                fill_addr_d = fill_addr_q + AW'(1);
                fill_left_d = fill_left_q - FW'(1);
            end
            if (busy_cnt_q != '0) begin
                busy_cnt_d = busy_cnt_q - CW'(1);
            end else if (fill_left_q == '0) begin
                wip_d = 1'b0;
                wel_d = 1'b0;
            end
        end

        if (cs_rise) begin
            state_d     = IDLE;
            oe_d        = 1'b0;
            miso_d      = 1'b1;
            wr_any_d    = 1'b0;
            erase_arm_d = 1'b0;
            if (state_q == WR_DATA && wr_any_q) begin
                wip_d      = 1'b1;
                busy_cnt_d = CW'(PROG_CYCLES - 1);
            end else if (state_q == IGNORE && erase_arm_q && wel_q && !wip_q) begin
                wip_d       = 1'b1;
                busy_cnt_d  = CW'(ERASE_CYCLES - 1);
                fill_addr_d = addr_q & ~LOW_MASK;
                fill_left_d = FW'(SECT_SIZE);
            end
        end else if (cs_fall) begin
            state_d     = CMD;
            bit_cnt_d   = 3'd7;
            oe_d        = 1'b0;
            miso_d      = 1'b1;
            wr_any_d    = 1'b0;
            erase_arm_d = 1'b0;
        end else if (state_q != IDLE) begin
            if (sck_fall && oe_q) begin
                miso_d  = tx_sr_q[7];
                tx_sr_d = {tx_sr_q[6:0], 1'b1};
            end
            if (sck_rise) begin
                rx_sr_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q - 3'd1;
                // Any clock after the 24th erase address bit cancels the erase
                if (state_q == IGNORE) begin
                    erase_arm_d = 1'b0;
                end
                if (bit_cnt_q == 3'd0) begin
                    case (state_q)
                        CMD: begin
                            strobe_d   = 1'b1;
                            code_d     = rx_byte;
                            addr_cnt_d = 2'd0;
                            state_d    = IGNORE;
                            if (!wip_q || rx_byte == OP_RDSR) begin
                                case (rx_byte)
                                    OP_WREN: wel_d = 1'b1;
                                    OP_WRDI: wel_d = 1'b0;
                                    OP_RDSR: begin
                                        state_d = STATUS;
                                        tx_sr_d = status_byte(wel_q, wip_q);
                                        oe_d    = 1'b1;
                                    end
                                    OP_READ, OP_RDID, OP_PP, OP_SE: state_d = ADDR;
`ifdef FLASH_SPI_RESP_FAST_READ_EN
                                    OP_FREAD: state_d = ADDR;
`endif
                                    default: state_d = IGNORE;
                                endcase
                            end
                        end
                        ADDR: begin
                            addr_acc_d = new_addr;
                            addr_cnt_d = addr_cnt_q + 2'd1;
                            if (addr_cnt_q == 2'd2) begin
                                addr_d  = new_addr;
                                state_d = IGNORE;
                                case (code_q)
                                    OP_READ: begin
                                        tx_sr_d = mem_rdata;
                                        addr_d  = new_addr + AW'(1);
                                        oe_d    = 1'b1;
                                        state_d = RD_DATA;
                                    end
                                    OP_RDID: begin
                                        tx_sr_d  = MFR_ID;
                                        id_sel_d = 1'b1;
                                        oe_d     = 1'b1;
                                        state_d  = ID_OUT;
                                    end
                                    OP_PP:    state_d = wel_q ? WR_DATA : IGNORE;
                                    OP_SE:    erase_arm_d = 1'b1;
                                    OP_FREAD: state_d = DUMMY;
                                    default:  state_d = IGNORE;
                                endcase
                            end
                        end
                        DUMMY, RD_DATA: begin
                            tx_sr_d = mem_rdata;
                            addr_d  = addr_q + AW'(1);
                            oe_d    = 1'b1;
                            state_d = RD_DATA;
                        end
                        STATUS: tx_sr_d = status_byte(wel_q, wip_q);
                        ID_OUT: begin
                            tx_sr_d  = id_sel_q ? DEV_ID : MFR_ID;
                            id_sel_d = ~id_sel_q;
                        end
                        WR_DATA: begin
                            // Programming can only clear bits; address wraps inside the page
                            mem_we    = 1'b1;
                            mem_waddr = addr_q;
                            mem_wdata = mem_rdata & rx_byte;
                            addr_d    = (addr_q & ~PAGE_MASK) | ((addr_q + AW'(1)) & PAGE_MASK);
                            wr_any_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Protocol and busy state registers
    always_ff @(posedge clock25M or negedge flash_rstn) begin
        if (!flash_rstn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 7'd0;
            tx_sr_q     <= 8'hFF;
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            wip_q       <= 1'b0;
            wel_q       <= 1'b0;
            strobe_q    <= 1'b0;
            code_q      <= 8'h00;
            addr_q      <= '0;
            addr_acc_q  <= '0;
            addr_cnt_q  <= 2'd0;
            id_sel_q    <= 1'b0;
            wr_any_q    <= 1'b0;
            erase_arm_q <= 1'b0;
            busy_cnt_q  <= '0;
            fill_addr_q <= '0;
            fill_left_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wip_q       <= wip_d;
            wel_q       <= wel_d;
            strobe_q    <= strobe_d;
            code_q      <= code_d;
            addr_q      <= addr_d;
            addr_acc_q  <= addr_acc_d;
            addr_cnt_q  <= addr_cnt_d;
            id_sel_q    <= id_sel_d;
            wr_any_q    <= wr_any_d;
            erase_arm_q <= erase_arm_d;
            busy_cnt_q  <= busy_cnt_d;
            fill_addr_q <= fill_addr_d;
            fill_left_q <= fill_left_d;
        end
    end

    // Memory array write port; contents are deliberately not touched by reset
    always_ff @(posedge clock25M) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign busy        = wip_q;
    assign wel         = wel_q;
    assign cmd_strobe  = strobe_q;
    assign cmd_code    = code_q;

endmodule

// File: tb/tb_flash_spi_responder.sv
// Self-checking bench for flash_spi_responder: directed flows plus randomized
// commands against a byte-array reference model. MISO bytes are collected by a
// monitor and compared with an expected-byte queue filled by the drivers.
module tb_flash_spi_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int PROG  = 64;
    localparam int ERASE = 1024;
    localparam int HALF  = 5;

    logic       clock25M = 1'b0;
    logic       flash_rstn;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       busy;
    logic       wel;
    logic       cmd_strobe;
    logic [7:0] cmd_code;

    flash_spi_responder #(
        .AW           (AW),
        .MFR_ID       (8'hEF),
        .DEV_ID       (8'h16),
        .PROG_CYCLES  (PROG),
        .ERASE_CYCLES (ERASE)
    ) dut (
        .clock25M    (clock25M),
        .flash_rstn  (flash_rstn),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .busy        (busy),
        .wel         (wel),
        .cmd_strobe  (cmd_strobe),
        .cmd_code    (cmd_code)
    );

    // Clock
    always #20 clock25M = ~clock25M;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [DEPTH];
    logic wel_m = 1'b0;
    int drv_bits = 0;
    int strobe_cnt = 0;
    int busy_rises = 0;
    int busy_len = 0;
    int busy_run = 0;
    int mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor: assembles driven MISO bits into bytes, pops expectations
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            mon_cnt = 0;
        end else if (spi_miso_oe) begin
            drv_bits++;
            mon_byte = {mon_byte[6:0], spi_miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL miso_extra: got %0h expected none", mon_byte);
                end else begin
                    check("miso_byte", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Status observers: strobe pulses and busy pulse widths
    always @(negedge clock25M) begin
        if (cmd_strobe) strobe_cnt++;
        if (busy) begin
            if (busy_run == 0) busy_rises++;
            busy_run++;
        end else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clocks(input int n);
        repeat (n) @(negedge clock25M);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            clocks(HALF);
            spi_sck = 1'b1;
            clocks(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic cs_lo();
        spi_cs_n = 1'b0;
        clocks(HALF);
    endtask

    task automatic cs_hi();
        clocks(HALF);
        spi_cs_n = 1'b1;
        clocks(2 * HALF);
    endtask

    task automatic send_op(input logic [7:0] op);
        int c;
        c = strobe_cnt;
        spi_byte(op);
        clocks(1);
        check("strobe_count", strobe_cnt, c + 1);
        check("cmd_code", {24'h0, cmd_code}, {24'h0, op});
    endtask

    task automatic send_addr(input int a);
        logic [23:0] v;
        v = 24'(a);
        spi_byte(v[23:16]);
        spi_byte(v[15:8]);
        spi_byte(v[7:0]);
    endtask

    function automatic int page_next(input int a, input int i);
        return (a & ~32'hFF) | ((a + i) & 32'hFF);
    endfunction

    task automatic wait_not_busy(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            clocks(1);
            n++;
        end
        check("busy_timeout", {31'h0, busy}, 32'h0);
        clocks(2);
    endtask

    task automatic do_wren();
        cs_lo(); send_op(8'h06); cs_hi();
        wel_m = 1'b1;
        check("wel_after_wren", {31'h0, wel}, 32'h1);
    endtask

    task automatic do_wrdi();
        cs_lo(); send_op(8'h04); cs_hi();
        wel_m = 1'b0;
        check("wel_after_wrdi", {31'h0, wel}, 32'h0);
    endtask

    task automatic do_status(input int n, input logic wip_exp);
        for (int i = 0; i < n; i++) exp_q.push_back({6'b0, wel_m, wip_exp});
        cs_lo(); send_op(8'h05);
        for (int i = 0; i < n; i++) spi_byte(8'h00);
        cs_hi();
    endtask

    task automatic do_read(input int a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_m[(a + i) % DEPTH]);
        cs_lo(); send_op(8'h03); send_addr(a);
        for (int i = 0; i < n; i++) spi_byte(8'h00);
        cs_hi();
    endtask

    task automatic do_id(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back((i % 2 == 0) ? 8'hEF : 8'h16);
        cs_lo(); send_op(8'h90); send_addr(0);
        for (int i = 0; i < n; i++) spi_byte(8'h00);
        cs_hi();
    endtask

    task automatic do_fast_read(input int a, input int n);
        int d0;
        d0 = drv_bits;
`ifdef FLASH_SPI_RESP_FAST_READ_EN
        for (int i = 0; i < n; i++) exp_q.push_back(mem_m[(a + i) % DEPTH]);
`endif
        cs_lo(); send_op(8'h0B); send_addr(a); spi_byte(8'h00);
        for (int i = 0; i < n; i++) spi_byte(8'h00);
        cs_hi();
`ifdef FLASH_SPI_RESP_FAST_READ_EN
        check("fast_read_drive_bits", drv_bits - d0, 8 * n);
`else
        check("fast_read_drive_bits", drv_bits - d0, 0);
`endif
    endtask

    // Program n bytes taken MSB-first from data
    task automatic do_prog(input int a, input logic [31:0] data, input int n);
        int r0;
        logic [7:0] b;
        r0 = busy_rises;
        cs_lo(); send_op(8'h02); send_addr(a);
        for (int i = 0; i < n; i++) begin
            b = data[31 - 8 * i -: 8];
            spi_byte(b);
            if (wel_m) mem_m[page_next(a, i)] = mem_m[page_next(a, i)] & b;
        end
        cs_hi();
        if (wel_m) begin
            wait_not_busy(PROG + 200);
            check("prog_busy_rises", busy_rises, r0 + 1);
            check_range("prog_busy_len", busy_len, PROG, PROG + 2);
            wel_m = 1'b0;
            check("wel_after_prog", {31'h0, wel}, 32'h0);
        end else begin
            clocks(8);
            check("no_wel_busy", {31'h0, busy}, 32'h0);
            check("no_wel_busy_rises", busy_rises, r0);
        end
    endtask

    // Starts a sector erase; the model is updated immediately
    task automatic start_erase(input int a);
        cs_lo(); send_op(8'h20); send_addr(a); cs_hi();
        if (wel_m) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
        end
    endtask

    // Watchdog
    initial begin
        #(90000 * 40);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        int d0;
        int c0;
        int r;
        int a;
        int n;
        flash_rstn = 1'b0;
        spi_cs_n   = 1'b1;
        spi_sck    = 1'b0;
        spi_mosi   = 1'b0;
        clocks(5);
        check("rst_miso", {31'h0, spi_miso}, 32'h1);
        check("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_wel", {31'h0, wel}, 32'h0);
        check("rst_strobe", {31'h0, cmd_strobe}, 32'h0);
        check("rst_code", {24'h0, cmd_code}, 32'h0);
        flash_rstn = 1'b1;
        clocks(5);

        // ID read
        do_id(2);
        do_id(4);

        // Full erase (sector covers the whole array), busy behaviour
        do_wren();
        r = busy_rises;
        start_erase(0);
        check("erase_busy", {31'h0, busy}, 32'h1);
        do_status(1, 1'b1);
        d0 = drv_bits;
        cs_lo(); send_op(8'h03); send_addr(32'h3FF); spi_byte(8'h00); spi_byte(8'h00); cs_hi();
        check("read_during_busy_drive", drv_bits - d0, 0);
        check("still_busy", {31'h0, busy}, 32'h1);
        wait_not_busy(ERASE + 500);
        check("erase_busy_rises", busy_rises, r + 1);
        check_range("erase_busy_len", busy_len, ERASE, ERASE + 6);
        wel_m = 1'b0;
        check("wel_after_erase", {31'h0, wel}, 32'h0);
        do_read(32'h3FF, 2);

        // WREN, status, page program with wrap, read back
        do_wren();
        do_status(2, 1'b0);
        do_prog(32'h0FE, 32'h11223300, 3);
        do_read(32'h0FE, 2);
        do_read(32'h000, 1);
        do_status(1, 1'b0);

        // Program without WREN, AND semantics
        do_prog(32'h010, 32'h00000000, 1);
        do_read(32'h010, 1);
        do_wren();
        do_prog(32'h020, 32'hF0000000, 1);
        do_wren();
        do_prog(32'h020, 32'h0F000000, 1);
        do_read(32'h020, 1);

        // WRDI and erase without WEL
        do_wren();
        do_wrdi();
        do_status(1, 1'b0);
        r = busy_rises;
        start_erase(0);
        clocks(10);
        check("erase_no_wel_rises", busy_rises, r);

        // Fast read (decoded only when the option is built in)
        do_fast_read(32'h0FE, 3);

        // Randomized mix
        for (int it = 0; it < 24; it++) begin
            a = int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(1, 4));
            case ($urandom_range(0, 4))
                0: do_read(a, n);
                1: begin do_wren(); do_prog(a, $urandom, n); end
                2: do_prog(a, $urandom, n);
                3: do_status(n, 1'b0);
                default: do_id(n);
            endcase
        end
        do_read(32'h0F8, 12);

        // Partial opcode is discarded
        c0 = strobe_cnt;
        cs_lo(); spi_bits(8'h90, 5); cs_hi();
        check("partial_no_strobe", strobe_cnt, c0);
        check("partial_no_drive_oe", {31'h0, spi_miso_oe}, 32'h0);
        do_id(2);

        // Reset in the middle of an erase
        do_wren();
        start_erase(0);
        clocks(100);
        check("erase_running", {31'h0, busy}, 32'h1);
        flash_rstn = 1'b0;
        clocks(3);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_wel", {31'h0, wel}, 32'h0);
        check("abort_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("abort_miso", {31'h0, spi_miso}, 32'h1);
        flash_rstn = 1'b1;
        wel_m = 1'b0;
        clocks(5);
        check("abort_stays_idle", {31'h0, busy}, 32'h0);
        do_id(2);
        do_status(1, 1'b0);

        clocks(10);
        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
